mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter PC_W, default 32, PC register width.
REQ-002 Parameter RESET_PC, default 'h80, PC value loaded on reset.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ins  input  32  instruction word at address pc, combinational from fetch.
REQ-007 zero  input  1  ALU zero flag, combinational from execute.
REQ-008 mem_ready  input  1  data-memory completion for current mem_read/mem_write.
REQ-009 pc  output  PC_W  current instruction address.
REQ-010 reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg  output  1 each  datapath controls.
REQ-011 alu_op  output  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-012 halted  output  1  FSM in HALT.
REQ-013 illegal  output  1  HALT entered because of an undecodable instruction.
REQ-014 retired  output  CNT_W  count of completed instructions.
REQ-015 state  output  3  encoded FSM state, for debug.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-017 FETCH SHALL last one cycle and latch ins into an internal ir.
REQ-018 DECODE SHALL classify ir:
- R-type: op 0, funct 20/22/24/25/2a.
- addi 08, lw 23, sw 2b, beq 04, j 02, halt 3F.
- Anything else, including an R-type with another funct, SHALL go to HALT with illegal=1.
- halt SHALL go to HALT with illegal=0.
- All valid classes SHALL go to EXEC.
REQ-019 From EXEC:
- R-type and addi SHALL go to WB.
- lw and sw SHALL go to MEM.
- beq and j SHALL go to FETCH.
REQ-020 MEM SHALL hold mem_read (lw) or mem_write (sw) high until a cycle with mem_ready=1.
- On that cycle, lw SHALL go to WB and sw SHALL go to FETCH.
- A mem_ready=1 on the first MEM cycle SHALL complete with zero wait.
REQ-021 reg_write SHALL be high only in WB; mem_read/mem_write SHALL be high only in MEM.
REQ-022 In EXEC, MEM and WB the remaining controls SHALL be driven from ir:
- reg_dst=1 for R-type only.
- alu_src=1 for addi/lw/sw.
- mem2reg=1 for lw only.
- alu_op from funct for R-type, 010 for addi/lw/sw, 110 for beq.
REQ-023 In FETCH, DECODE and HALT all datapath controls SHALL be 0 and alu_op SHALL be 010.
REQ-024 On leaving the last state of an instruction, pc SHALL be updated as follows:
- beq with zero=1 sampled in EXEC: pc <= pc+4+(sign-extended ir[15:0] << 2).
- j: pc <= {ir[25:0],2'b00}, zero-extended or truncated to PC_W.
- All others: pc <= pc+4.
- All PC arithmetic SHALL be modulo 2^PC_W.
REQ-025 retired SHALL increment by 1 each time an instruction leaves WB, MEM (sw) or EXEC (beq/j), saturating at all-ones.
REQ-026 halt and illegal instructions SHALL NOT count as retired, and pc SHALL stay at the address of the offending instruction.
REQ-027 HALT SHALL be absorbing until reset; ins, zero and mem_ready SHALL be ignored in HALT.

Reset
REQ-028 While rst_n=0 the block SHALL asynchronously force the following:
- state=FETCH.
- pc=RESET_PC.
- ir=0.
- retired=0.
- halted=0, illegal=0.
- All controls 0, alu_op=010.
REQ-029 Reset asserted mid-instruction, including mid-MEM wait, SHALL abort the instruction with no pc or counter update.
REQ-030 After reset release, the first FETCH SHALL occur at the first rising edge.

Structure
REQ-031 Opcode/funct constants, alu_op codes and the state encoding SHALL live in shared package mc_pkg.
REQ-032 The funct-to-alu_op and legality decode SHALL be a combinational sub-module mc_alu_dec.
REQ-033 PC, ir, state and retired SHALL be the only registers.

Verification
REQ-034 add $3,$1,$2 (00221820) at 'h80 -> FETCH,DECODE,EXEC,WB; reg_dst=1 and reg_write=1 in WB; alu_op=010; pc 'h84; retired 1.
REQ-035 lw with mem_ready low 3 cycles -> mem_read high 4 cycles, then WB with mem2reg=1; pc +4.
REQ-036 beq imm=-2 with zero=1 at pc 'h90 -> pc 'h8C.
REQ-037 beq at pc 'h90 with zero=0 -> pc 'h94.
REQ-038 j target 'h20 -> pc 'h80; retired +1 in both branch and jump cases.
REQ-039 Opcode 3F at 'h84 -> halted=1, illegal=0, pc stays 'h84.
REQ-040 R-type funct 'h00 -> halted=1, illegal=1; retired unchanged.
REQ-041 rst_n pulsed low during a MEM wait -> pc='h80, state=FETCH, retired=0, mem_read=0, all asynchronously before the next edge.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared opcode/funct constants, ALU op codes, FSM state and instruction class encodings.
package mc_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_ADDI = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_BEQ  = 3'd4,
    C_J    = 3'd5,
    C_HALT = 3'd6,
    C_ILL  = 3'd7
  } cls_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3f;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: classifies an instruction word and derives its execute-stage ALU operation.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] alu_op
);
  logic       r_ok;
  logic [2:0] r_op;
  always_comb begin
    r_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    r_op = funct == FN_SUB ? ALU_SUB :
           funct == FN_AND ? ALU_AND :
           funct == FN_OR  ? ALU_OR  :
           funct == FN_SLT ? ALU_SLT : ALU_ADD;
    case (op)
      OP_R:    cls = r_ok ? C_R : C_ILL;
      OP_ADDI: cls = C_ADDI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_HALT: cls = C_HALT;
      default: cls = C_ILL;
    endcase
    alu_op = cls == C_R ? r_op : cls == C_BEQ ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with PC, retired counter and HALT trap.
module mc_control
  import mc_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 'h80,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem2reg,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);
  state_t          st;
  cls_t            cls;
  logic [31:0]     ir;
  logic [2:0]      dec_op;
  logic            act;
  logic            done;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_next;
  mc_alu_dec u_dec (
    .op     (ir[31:26]),
    .funct  (ir[5:0]),
    .cls    (cls),
    .alu_op (dec_op)
  );
  // Controls are pure decodes of state and ir so reset clears them immediately.
  assign act       = st inside {S_EXEC, S_MEM, S_WB};
  assign reg_dst   = act && cls == C_R;
  assign alu_src   = act && cls inside {C_ADDI, C_LW, C_SW};
  assign mem2reg   = act && cls == C_LW;
  assign alu_op    = act ? dec_op : ALU_ADD;
  assign reg_write = st == S_WB;
  assign mem_read  = st == S_MEM && cls == C_LW;
  assign mem_write = st == S_MEM && cls == C_SW;
  assign halted    = st == S_HALT;
  assign illegal   = halted && cls == C_ILL;
  assign state     = st;
  always_comb begin
    off     = PC_W'($signed(ir[15:0]));
    pc_seq  = pc + PC_W'(4);
    done    = (st == S_EXEC && (cls == C_BEQ || cls == C_J)) ||
              (st == S_MEM && mem_ready && cls == C_SW) || st == S_WB;
    pc_next = cls == C_J ? PC_W'({ir[25:0], 2'b00}) :
              (cls == C_BEQ && zero) ? pc_seq + (off << 2) : pc_seq;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      retired <= '0;
    end else begin
      if (done) begin
        pc      <= pc_next;
        retired <= retired + CNT_W'(~&retired);
      end
      case (st)
        S_FETCH: begin
          ir <= ins;
          st <= S_DECODE;
        end
        S_DECODE: st <= (cls == C_HALT || cls == C_ILL) ? S_HALT : S_EXEC;
        S_EXEC:   st <= (cls == C_R || cls == C_ADDI) ? S_WB :
                        (cls == C_LW || cls == C_SW) ? S_MEM : S_FETCH;
        S_MEM:    st <= !mem_ready ? S_MEM : cls == C_LW ? S_WB : S_FETCH;
        S_WB:     st <= S_FETCH;
        default:  st <= S_HALT;
      endcase
    end
  end
endmodule
